// File: rtl/mono_data_tx_pkg.sv
// mono_data_tx_pkg: shared constants, word field layout, FSM states and Gray helper
// for the Monopix readout emulator. The optional Gray timestamp encoding in the
// top level is enabled by defining MONO_DATA_TX_GRAY_EN.
package mono_data_tx_pkg;

  localparam int unsigned WORD_W_DEF = 26;
  localparam int unsigned ERR_W      = 8;

  // Hit word layout {COL, ROW, LE, TE}, MSB first on the wire
  localparam int unsigned TE_W    = 6;
  localparam int unsigned LE_W    = 6;
  localparam int unsigned ROW_W   = 8;
  localparam int unsigned COL_W   = 6;
  localparam int unsigned TE_OFF  = 0;
  localparam int unsigned LE_OFF  = TE_OFF + TE_W;
  localparam int unsigned ROW_OFF = LE_OFF + LE_W;
  localparam int unsigned COL_OFF = ROW_OFF + ROW_W;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Binary to Gray for a 6-bit timestamp field
  function automatic logic [5:0] bin2gray(input logic [5:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/mono_data_tx_fifo.sv
// mono_data_tx_fifo: synchronous hit FIFO with occupancy count. Pointers carry one
// extra wrap bit so full and empty are distinguishable from the difference alone.
module mono_data_tx_fifo #(
  parameter int unsigned W     = 26,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_b,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rdata_c,
  output logic [$clog2(DEPTH):0]   o_count_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;

  // Pointer update; cleared by reset so the FIFO comes up empty
  always_ff @(posedge i_clk) begin
    if (!i_rst_b) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PW'(1);
      if (i_pop)  r_rptr <= r_rptr + PW'(1);
    end
  end

  // Storage write
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata_c = r_mem[r_rptr[AW-1:0]];
  assign o_count_c = r_wptr - r_rptr;

endmodule

// File: rtl/mono_data_tx.sv
// mono_data_tx: Monopix readout periphery emulator. Queues hit words, raises TOKEN,
// and serialises one word per READ edge on DATA. FREEZE snapshots the set of words
// offered through TOKEN. Define MONO_DATA_TX_GRAY_EN to Gray-encode LE/TE at load.
module mono_data_tx
  import mono_data_tx_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              CLK,
  input  logic              RST_B,
  input  logic [WORD_W-1:0] HIT_DATA,
  input  logic              HIT_VALID,
  output logic              HIT_READY,
  input  logic              READ,
  input  logic              FREEZE,
  output logic              TOKEN,
  output logic              DATA,
  output logic              BUSY,
  output logic [ERR_W-1:0]  RD_ERR_CNT
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned BW = $clog2(WORD_W);

  logic [CW-1:0]     w_count;
  logic [WORD_W-1:0] w_head;
  logic [WORD_W-1:0] w_load_word;
  logic              w_push;
  logic              w_load;
  logic              w_avail;
  logic              w_frozen;
  logic              w_frz_rise;
  logic              w_frz_fall;
  logic              w_rd_ign;

  logic              r_read_q;
  logic              r_read_qq;
  logic              r_rd_edge;
  logic              r_frz_q;
  logic              r_frz_qq;
  logic              r_ready_en;
  logic              r_token;
  logic [CW-1:0]     r_frz_cnt;
  logic [ERR_W-1:0]  r_err_cnt;
  state_e            r_state;
  logic [BW-1:0]     r_bit_cnt;
  logic [WORD_W-1:0] r_shreg;
  logic              r_busy;

  mono_data_tx_fifo #(
    .W     (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk     (CLK),
    .i_rst_b   (RST_B),
    .i_push    (w_push),
    .i_wdata   (HIT_DATA),
    .i_pop     (w_load),
    .o_rdata_c (w_head),
    .o_count_c (w_count)
  );

  // Frozen state follows the second FREEZE stage so FRZ_CNT is already valid
  assign w_frozen   = r_frz_qq;
  assign w_frz_rise = r_frz_q & ~r_frz_qq;
  assign w_frz_fall = ~r_frz_q & r_frz_qq;
  assign w_avail    = w_frozen ? (r_frz_cnt != '0) : (w_count != '0);
  assign w_load     = (r_state == IDLE) & r_rd_edge & w_avail;
  assign w_rd_ign   = r_rd_edge & ~w_load;
  assign w_push     = HIT_VALID & HIT_READY;

  assign HIT_READY  = r_ready_en & (w_count != CW'(DEPTH));
  assign TOKEN      = r_token;
  assign DATA       = r_shreg[WORD_W-1];
  assign BUSY       = r_busy;
  assign RD_ERR_CNT = r_err_cnt;

  // Word as placed on the wire; timestamps optionally Gray-coded
  always_comb begin
    w_load_word = w_head;
`ifdef MONO_DATA_TX_GRAY_EN
    w_load_word[LE_OFF +: LE_W] = bin2gray(w_head[LE_OFF +: LE_W]);
    w_load_word[TE_OFF +: TE_W] = bin2gray(w_head[TE_OFF +: TE_W]);
`endif
  end

  // Input synchronisers, READ edge register, ready enable and TOKEN
  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      r_read_q   <= 1'b0;
      r_read_qq  <= 1'b0;
      r_rd_edge  <= 1'b0;
      r_frz_q    <= 1'b0;
      r_frz_qq   <= 1'b0;
      r_ready_en <= 1'b0;
      r_token    <= 1'b0;
    end else begin
      r_read_q   <= READ;
      r_read_qq  <= r_read_q;
      r_rd_edge  <= r_read_q & ~r_read_qq;
      r_frz_q    <= FREEZE;
      r_frz_qq   <= r_frz_q;
      r_ready_en <= 1'b1;
      r_token    <= w_frozen ? (r_frz_cnt != '0) : (w_count != '0);
    end
  end

  // Freeze snapshot: words queued at the freeze edge, excluding one popped that cycle
  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      r_frz_cnt <= '0;
    end else if (w_frz_rise) begin
      r_frz_cnt <= w_count - CW'(w_load);
    end else if (w_frz_fall) begin
      r_frz_cnt <= '0;
    end else if (w_frozen && w_load) begin
      r_frz_cnt <= r_frz_cnt - CW'(1);
    end
  end

  // Saturating count of READ edges that could not be served
  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      r_err_cnt <= '0;
    end else if (w_rd_ign && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

  // Readout FSM: load on an accepted READ edge, then shift MSB first one bit per cycle
  always_ff @(posedge CLK) begin
    if (!RST_B) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_shreg   <= w_load_word;
            r_bit_cnt <= BW'(WORD_W - 1);
            r_busy    <= 1'b1;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          r_shreg <= {r_shreg[WORD_W-2:0], 1'b0};
          if (r_bit_cnt == '0) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_bit_cnt <= r_bit_cnt - BW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
